// File: rtl/board_io_pkg.sv
// Shared definitions for the board interrupt front-end: channel mode encodings
// and the per-channel edge-match helper.
package board_io_pkg;

  localparam logic [1:0] IRQ_MODE_LEVEL = 2'b00;
  localparam logic [1:0] IRQ_MODE_RISE  = 2'b01;
  localparam logic [1:0] IRQ_MODE_FALL  = 2'b10;
  localparam logic [1:0] IRQ_MODE_BOTH  = 2'b11;

  // True when the debounced edge seen this cycle is one the channel mode reacts to.
  function automatic logic irq_edge_hit(input logic [1:0] mode,
                                        input logic       rise,
                                        input logic       fall);
    logic hit;
    hit = 1'b0;
    case (mode)
      IRQ_MODE_RISE: hit = rise;
      IRQ_MODE_FALL: hit = fall;
      IRQ_MODE_BOTH: hit = rise | fall;
      default:       hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/irq_debounce_ch.sv
// One interrupt channel front-end: multi-flop synchroniser followed by a
// mismatch-counting debouncer that produces the stable input level.
module irq_debounce_ch #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_async,
  output logic o_stable
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_stable;
  logic [CNT_W-1:0]       r_cnt;
  logic                   w_mismatch;
  logic                   w_terminal;

  assign w_mismatch = r_sync[SYNC_STAGES-1] ^ r_stable;
  assign w_terminal = (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1));

  // The counter returns to zero on any agreeing cycle, so only an uninterrupted
  // run of DEBOUNCE_CYCLES mismatches moves the stable level.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sync   <= '0;
      r_stable <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
      if (!w_mismatch) begin
        r_cnt <= '0;
      end else if (w_terminal) begin
        r_stable <= r_sync[SYNC_STAGES-1];
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_stable = r_stable;

endmodule

// File: rtl/board_irq_conditioner.sv
// Board-level interrupt conditioner: debounced inputs, programmable edge/level
// detection, software-clearable pending latch and output mask per channel.
module board_irq_conditioner #(
  parameter int N_CH            = 7,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic              CLK100MHZ,
  input  logic              CPU_RESETN,
  input  logic [N_CH-1:0]   irq_in,
  input  logic [2*N_CH-1:0] irq_mode,
  input  logic [N_CH-1:0]   irq_mask,
  input  logic [N_CH-1:0]   irq_clr,
  output logic [N_CH-1:0]   irq_out,
  output logic [N_CH-1:0]   irq_pending,
  output logic [N_CH-1:0]   irq_stable
);

  import board_io_pkg::*;

  logic [N_CH-1:0]   w_stable;
  logic [N_CH-1:0]   r_stable_d;
  logic [N_CH-1:0]   w_rise;
  logic [N_CH-1:0]   w_fall;
  logic [N_CH-1:0]   r_pending;
  logic [N_CH-1:0]   w_pending_nxt;
  logic [2*N_CH-1:0] r_mode_prev;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    irq_debounce_ch #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
      .i_clk    (CLK100MHZ),
      .i_rst_n  (CPU_RESETN),
      .i_async  (irq_in[g]),
      .o_stable (w_stable[g])
    );
  end

  assign w_rise =  w_stable & ~r_stable_d;
  assign w_fall = ~w_stable &  r_stable_d;

  // Priority per channel: mode change, then level tracking, then edge set over clear.
  always_comb begin
    w_pending_nxt = r_pending;
    for (int k = 0; k < N_CH; k++) begin
      if (irq_mode[2*k +: 2] != r_mode_prev[2*k +: 2]) begin
        w_pending_nxt[k] = 1'b0;
      end else if (irq_mode[2*k +: 2] == IRQ_MODE_LEVEL) begin
        w_pending_nxt[k] = w_stable[k];
      end else if (irq_edge_hit(irq_mode[2*k +: 2], w_rise[k], w_fall[k])) begin
        w_pending_nxt[k] = 1'b1;
      end else if (irq_clr[k]) begin
        w_pending_nxt[k] = 1'b0;
      end
    end
  end

  always_ff @(posedge CLK100MHZ) begin
    if (!CPU_RESETN) begin
      r_stable_d  <= '0;
      r_pending   <= '0;
      r_mode_prev <= '0;
    end else begin
      r_stable_d  <= w_stable;
      r_pending   <= w_pending_nxt;
      r_mode_prev <= irq_mode;
    end
  end

  assign irq_out     = r_pending & irq_mask;
  assign irq_pending = r_pending;
  assign irq_stable  = w_stable;

endmodule

// File: tb/tb_board_irq_conditioner.sv
// Directed bench for board_irq_conditioner with 4 channels, 2 sync stages and
// a 16-cycle debounce window.
module tb_board_irq_conditioner;

  localparam int N_CH = 4;

  logic            clk;
  logic            rst_n;
  logic [N_CH-1:0] irq_in;
  logic [2*N_CH-1:0] irq_mode;
  logic [N_CH-1:0] irq_mask;
  logic [N_CH-1:0] irq_clr;
  logic [N_CH-1:0] irq_out;
  logic [N_CH-1:0] irq_pending;
  logic [N_CH-1:0] irq_stable;

  int total = 0;
  int bad   = 0;
  logic seen;

  board_irq_conditioner #(
    .N_CH            (N_CH),
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (16)
  ) dut (
    .CLK100MHZ   (clk),
    .CPU_RESETN  (rst_n),
    .irq_in      (irq_in),
    .irq_mode    (irq_mode),
    .irq_mask    (irq_mask),
    .irq_clr     (irq_clr),
    .irq_out     (irq_out),
    .irq_pending (irq_pending),
    .irq_stable  (irq_stable)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    irq_in   = 4'hF;
    irq_mode = 8'h35;
    irq_mask = 4'hF;
    irq_clr  = 4'h0;

    step(5);
    chk("rst_stable",  irq_stable,  4'h0);
    chk("rst_pending", irq_pending, 4'h0);
    chk("rst_out",     irq_out,     4'h0);

    rst_n    = 1'b1;
    irq_mask = 4'h0;
    step(17);
    chk("rel_stable_17", irq_stable, 4'h0);
    step(1);
    chk("rel_stable_18", irq_stable, 4'hF);
    chk("rel_pending_18", irq_pending, 4'h0);
    step(1);
    chk("rel_pending_19", irq_pending, 4'hF);

    irq_in = 4'h0;
    step(19);
    chk("drop_stable", irq_stable, 4'h0);
    chk("drop_pending", irq_pending, 4'h7);
    irq_clr = 4'hF;
    step(1);
    irq_clr = 4'h0;
    chk("clr_all", irq_pending, 4'h0);

    seen = 1'b0;
    irq_in[0] = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (i == 10) irq_in[0] = 1'b0;
      step(1);
      seen = seen | irq_stable[0] | irq_pending[0];
    end
    chk("glitch_ch0", seen, 1'b0);

    irq_mask  = 4'b0010;
    irq_in[1] = 1'b1;
    step(18);
    chk("rise_ch1_18", irq_out[1], 1'b0);
    step(1);
    chk("rise_ch1_19", irq_out[1], 1'b1);
    step(21);
    irq_in[1] = 1'b0;
    step(25);
    chk("rise_ch1_hold", irq_out[1], 1'b1);
    irq_clr = 4'b0010;
    step(1);
    irq_clr = 4'h0;
    chk("rise_ch1_clr_out", irq_out[1], 1'b0);
    chk("rise_ch1_clr_pend", irq_pending[1], 1'b0);

    irq_in[2] = 1'b1;
    step(19);
    chk("both_ch2_rise", irq_pending[2], 1'b1);
    irq_clr = 4'b0100;
    step(1);
    irq_clr = 4'h0;
    chk("both_ch2_clr", irq_pending[2], 1'b0);
    irq_in[2] = 1'b0;
    step(18);
    chk("both_ch2_fell", irq_stable[2], 1'b0);
    irq_clr = 4'b0100;
    step(1);
    irq_clr = 4'h0;
    chk("collision_ch2", irq_pending[2], 1'b1);
    irq_clr = 4'b0100;
    step(1);
    irq_clr = 4'h0;
    chk("both_ch2_clr2", irq_pending[2], 1'b0);

    irq_mask  = 4'h0;
    irq_in[3] = 1'b1;
    step(19);
    chk("lvl_ch3_pend", irq_pending[3], 1'b1);
    chk("lvl_ch3_masked", irq_out[3], 1'b0);
    irq_mask = 4'b1000;
    #1;
    chk("lvl_ch3_unmask", irq_out[3], 1'b1);
    irq_clr = 4'b1000;
    step(1);
    irq_clr = 4'h0;
    chk("lvl_ch3_clr_ignored", irq_pending[3], 1'b1);
    irq_in[3] = 1'b0;
    step(18);
    chk("lvl_ch3_drop_18", irq_pending[3], 1'b1);
    step(1);
    chk("lvl_ch3_drop_19", irq_pending[3], 1'b0);

    irq_in[1] = 1'b1;
    step(19);
    chk("mode_ch1_set", irq_pending[1], 1'b1);
    irq_mode = 8'h39;
    step(1);
    chk("mode_ch1_cleared", irq_pending[1], 1'b0);
    irq_in[1] = 1'b0;
    step(18);
    chk("mode_ch1_wait", irq_pending[1], 1'b0);
    step(1);
    chk("mode_ch1_fall", irq_pending[1], 1'b1);
    chk("others_pending", irq_pending & 4'b1101, 4'b0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
